// File: rtl/fsk_tx_sequencer.sv
// FSK transmit sequencer: preamble, start, 8 data bits LSB first, optional parity, stop.
// Build option: define FSK_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
//
// state    | meaning
// IDLE     | waiting for a byte, modulator off, line held at mark
// PREAMBLE | alternating 1,0,... bits before a frame that starts from IDLE
// START    | one space bit
// DATA     | eight latched bits, LSB first
// PARITY   | XOR of the data bits (FSK_TX_PARITY_EN builds only)
// STOP     | one mark bit; may accept the next byte for a gapless follow-on frame
module fsk_tx_sequencer #(
    parameter int BIT_DIV       = 50000,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tone_sel,
    output logic       tone_en,
    output logic       bit_strobe,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRE    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
`ifdef FSK_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif
    localparam logic [2:0] S_STOP   = 3'd5;

    localparam logic [15:0] CNT_LAST    = 16'(BIT_DIV - 1);
    localparam logic [3:0]  PRE_LAST    = 4'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam logic [2:0]  FIRST_STATE = (PREAMBLE_BITS > 0) ? S_PRE : S_START;
    localparam logic        FIRST_SEL   = (PREAMBLE_BITS > 0);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_pre_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_byte;
    logic        r_pend;
    logic        r_tx_ready;
    logic        r_tone_sel;
    logic        r_tone_en;
    logic        r_busy;

    logic        w_bit_end;
    logic        w_hs;

    assign w_bit_end = (r_state != S_IDLE) && (r_cnt == CNT_LAST);
    assign w_hs      = tx_valid && r_tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_pre_cnt  <= 4'd0;
            r_idx      <= 3'd0;
            r_byte     <= 8'd0;
            r_pend     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_tone_sel <= 1'b1;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_byte     <= tx_data;
                        r_state    <= FIRST_STATE;
                        r_pre_cnt  <= 4'd0;
                        r_idx      <= 3'd0;
                        r_tx_ready <= 1'b0;
                        r_tone_sel <= FIRST_SEL;
                        r_tone_en  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (w_bit_end) begin
                        if (r_pre_cnt == PRE_LAST) begin
                            r_state    <= S_START;
                            r_tone_sel <= 1'b0;
                        end else begin
                            r_pre_cnt  <= r_pre_cnt + 4'd1;
                            // even-numbered preamble bits are mark
                            r_tone_sel <= r_pre_cnt[0];
                        end
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state    <= S_DATA;
                        r_idx      <= 3'd0;
                        r_tone_sel <= r_byte[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef FSK_TX_PARITY_EN
                            r_state    <= S_PARITY;
                            r_tone_sel <= ^r_byte;
`else
                            r_state    <= S_STOP;
                            r_tone_sel <= 1'b1;
                            r_tx_ready <= 1'b1;
                            r_pend     <= 1'b0;
`endif
                        end else begin
                            r_tone_sel <= r_byte[r_idx + 3'd1];
                        end
                    end
                end
`ifdef FSK_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= S_STOP;
                        r_tone_sel <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_pend     <= 1'b0;
                    end
                end
`endif
                S_STOP: begin
                    if (w_hs) begin
                        r_byte     <= tx_data;
                        r_pend     <= 1'b1;
                        r_tx_ready <= 1'b0;
                    end
                    // a byte taken on the final stop cycle still chains directly
                    if (w_bit_end) begin
                        if (r_pend || w_hs) begin
                            r_state    <= S_START;
                            r_tone_sel <= 1'b0;
                            r_tx_ready <= 1'b0;
                            r_pend     <= 1'b0;
                        end else begin
                            r_state    <= S_IDLE;
                            r_tone_sel <= 1'b1;
                            r_tone_en  <= 1'b0;
                            r_busy     <= 1'b0;
                            r_tx_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = r_tx_ready;
    assign tone_sel   = r_tone_sel;
    assign tone_en    = r_tone_en;
    assign busy       = r_busy;
    assign bit_strobe = (r_state != S_IDLE) && (r_cnt == 16'd0);
    assign frame_done = (r_state == S_STOP) && (r_cnt == CNT_LAST);

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Bench for fsk_tx_sequencer: two instances (2-bit and no preamble) checked every cycle
// against a bit-list model, plus literal frame expectations.
module tb_fsk_tx_sequencer;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic [1:0] rdy, sel, en, stb, done, bsy;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    bit started = 1'b0;

    fsk_tx_sequencer #(.BIT_DIV(BD), .PREAMBLE_BITS(2)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[0]), .tone_sel(sel[0]), .tone_en(en[0]),
        .bit_strobe(stb[0]), .frame_done(done[0]), .busy(bsy[0]));

    fsk_tx_sequencer #(.BIT_DIV(BD), .PREAMBLE_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[1]), .tone_sel(sel[1]), .tone_en(en[1]),
        .bit_strobe(stb[1]), .frame_done(done[1]), .busy(bsy[1]));

    always #5 clk = ~clk;

    // model: each active frame is a list of bit values played out BD cycles per bit
    bit         m_act [2];
    int         m_c   [2];
    int         m_len [2];
    bit         m_seq [2][0:31];
    bit         m_pend[2];
    logic [7:0] m_pbyte[2];

    function automatic int pre_of(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic void build(int k, logic [7:0] b, int npre);
        int n = 0;
        for (int i = 0; i < npre; i++) begin m_seq[k][n] = (i % 2 == 0); n++; end
        m_seq[k][n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin m_seq[k][n] = b[i]; n++; end
`ifdef FSK_TX_PARITY_EN
        m_seq[k][n] = ^b; n++;
`endif
        m_seq[k][n] = 1'b1; n++;
        m_len[k] = n;
    endfunction

    function automatic bit exp_ready(int k);
        if (!m_act[k]) return 1'b1;
        return (m_c[k] / BD == m_len[k] - 1) && !m_pend[k];
    endfunction

    task automatic chk(string name, int k, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %b expected %b at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit hs;
            hs = tx_valid && exp_ready(k) && !rst;
            if (rst) begin
                m_act[k]  = 1'b0;
                m_pend[k] = 1'b0;
            end else if (!m_act[k]) begin
                if (hs) begin
                    build(k, tx_data, pre_of(k));
                    m_act[k] = 1'b1;
                    m_c[k]   = 0;
                end
            end else begin
                if (hs) begin
                    m_pend[k]  = 1'b1;
                    m_pbyte[k] = tx_data;
                end
                m_c[k]++;
                if (m_c[k] == m_len[k] * BD) begin
                    if (m_pend[k]) begin
                        build(k, m_pbyte[k], 0);
                        m_c[k]    = 0;
                        m_pend[k] = 1'b0;
                    end else begin
                        m_act[k] = 1'b0;
                    end
                end
            end
        end
        if (rst) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("tone_en", k, en[k], m_act[k]);
                chk("busy", k, bsy[k], m_act[k]);
                chk("tone_sel", k, sel[k], m_act[k] ? m_seq[k][m_c[k] / BD] : 1'b1);
                chk("bit_strobe", k, stb[k], m_act[k] && (m_c[k] % BD == 0));
                chk("frame_done", k, done[k], m_act[k] && (m_c[k] == m_len[k] * BD - 1));
                chk("tx_ready", k, rdy[k], exp_ready(k));
            end
            if (done[0]) done_cnt++;
        end
    end

    bit lit [0:15];
    int lit_n;

    task automatic run_lit(int k);
        for (int c = 0; c <= lit_n * BD; c++) begin
            if (c < lit_n * BD) begin
                chk("lit_tone_sel", k, sel[k], lit[c / BD]);
                chk("lit_tone_en", k, en[k], 1'b1);
                if (c % BD == 0) chk("lit_strobe", k, stb[k], 1'b1);
                if (c == lit_n * BD - 1) chk("lit_frame_done", k, done[k], 1'b1);
            end else begin
                chk("lit_tone_en_off", k, en[k], 1'b0);
                chk("lit_busy_off", k, bsy[k], 1'b0);
            end
            @(negedge clk);
        end
    endtask

    task automatic send(logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bsy != 2'b00 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bsy != 2'b00) begin
            n_bad++;
            $display("FAIL wait_idle: busy=%b expected 00", bsy);
        end
        #1;
    endtask

    task automatic chk_reset_vals(string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_ready"}, k, rdy[k], 1'b1);
            chk({name, "_en"}, k, en[k], 1'b0);
            chk({name, "_sel"}, k, sel[k], 1'b1);
            chk({name, "_busy"}, k, bsy[k], 1'b0);
            chk({name, "_strobe"}, k, stb[k], 1'b0);
            chk({name, "_done"}, k, done[k], 1'b0);
        end
    endtask

    initial begin
        int d0;
        int t;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset_idle");

        // 0xA5 from idle: literal bit list on the 2-bit-preamble instance
`ifdef FSK_TX_PARITY_EN
        lit[0:12] = '{1,0,0,1,0,1,0,0,1,0,1,0,1};
        lit_n = 13;
`else
        lit[0:11] = '{1,0,0,1,0,1,0,0,1,0,1,1};
        lit_n = 12;
`endif
        send(8'hA5);
        run_lit(0);
        wait_idle();

        // 0x01 with no preamble: starts straight with the start bit
`ifdef FSK_TX_PARITY_EN
        lit[0:10] = '{0,1,0,0,0,0,0,0,0,1,1};
        lit_n = 11;
`else
        lit[0:9] = '{0,1,0,0,0,0,0,0,0,1};
        lit_n = 10;
`endif
        send(8'h01);
        run_lit(1);
        wait_idle();

        // back-to-back: second byte offered during the first stop bit
        d0 = done_cnt;
        send(8'h00);
        t = 0;
        while (!(rdy[0] && bsy[0]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (!(rdy[0] && bsy[0])) begin
            n_bad++;
            $display("FAIL stop_ready_timeout: ready=%b busy=%b expected 1 1", rdy[0], bsy[0]);
        end
        send(8'hFF);
        wait_idle();
        n_cmp++;
        if (done_cnt - d0 != 2) begin
            n_bad++;
            $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
        end

        // reset during data bit 3 of the 2-bit-preamble instance
        d0 = done_cnt;
        send(8'h5A);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("mid_reset");
        repeat (BD * 3) @(negedge clk);
        #1;
        n_cmp++;
        if (done_cnt != d0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0);
        end
        @(negedge clk);
        send(8'h3C);
        wait_idle();
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL post_reset_frame: got %0d pulses expected 1", done_cnt - d0);
        end

        // random traffic with occasional resets
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            rst      = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
